// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Optional busy-cycle timeout with error reporting is enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_d;
    logic        grant_i;
    logic        grant_d;
    logic        timeout_hit;
    logic        complete;
    logic [31:0] rdata_cap;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // data has priority unless it won the previous grant
                if (d_req && (!i_req || !last_d)) begin
                    grant_d   = 1'b1;
                    state_nxt = DBUSY;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (m_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m_req     = (state == IBUSY) || (state == DBUSY);
    assign i_ready   = (state == DONE) && !last_d;
    assign d_ready   = (state == DONE) && last_d;
    assign complete  = m_req && (m_ack || timeout_hit);
    assign rdata_cap = m_ack ? m_rdata : 32'hDEADBEEF;

    // last_d doubles as the owner of the current transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= 4'h0;
            m_addr  <= 32'h0;
            m_wdata <= 32'h0;
            i_rdata <= 32'h0;
            d_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                last_d  <= 1'b1;
                m_we    <= d_we;
                m_be    <= d_be;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (grant_i) begin
                last_d  <= 1'b0;
                m_we    <= 1'b0;
                m_be    <= 4'hF;
                m_addr  <= i_addr;
                m_wdata <= 32'h0;
            end
            if (complete) begin
                if (state == DBUSY) begin
                    d_rdata <= rdata_cap;
                end else begin
                    i_rdata <= rdata_cap;
                end
            end
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt;
    logic       err_q;

    // fires in the busy cycle whose increment would make the count reach TIMEOUT; an ack wins
    assign timeout_hit = m_req && !m_ack && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= 8'h0;
            err_q  <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                to_cnt <= 8'h0;
            end else if (m_req && !m_ack) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (complete) begin
                err_q <= timeout_hit;
            end
        end
    end

    assign err = (state == DONE) && err_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^(8'(TIMEOUT));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level arbitration/latency model.
// Timeout expectations apply when MEM_ARBITER_TIMEOUT_EN is defined (TIMEOUT = 4).
module tb_mem_arbiter;

    localparam int TB_TO = 4;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          last_d;
    logic [31:0] exp_i_rd;
    logic [31:0] exp_d_rd;

    mem_arbiter #(.TIMEOUT(TB_TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_req"}, m_req, 0);
        check({tag, "_ready"}, {i_ready, d_ready}, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_i_rdata"}, i_rdata, exp_i_rd);
        check({tag, "_d_rdata"}, d_rdata, exp_d_rd);
    endtask

    // Called at a negedge while the DUT is idle with at least one request up.
    // Returns at the negedge of the idle cycle following the ready pulse.
    task automatic serve(input int lat, input logic [31:0] rd, input bit keep, output bit got_d);
        bit          own_d;
        bit          e_err;
        int          busy;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_we;
        logic [3:0]  e_be;
        own_d   = d_req && (!i_req || !last_d);
        e_addr  = own_d ? d_addr : i_addr;
        e_we    = own_d ? d_we : 1'b0;
        e_be    = own_d ? d_be : 4'hF;
        e_wdata = own_d ? d_wdata : 32'h0;
        busy    = lat;
        e_err   = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        if (lat > TB_TO) begin
            busy  = TB_TO;
            e_err = 1'b1;
        end
`endif
        e_rd = e_err ? 32'hDEADBEEF : rd;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= busy; k++) begin
            check("busy_m_req", m_req, 1);
            check("busy_m_addr", m_addr, e_addr);
            check("busy_m_we", m_we, e_we);
            check("busy_m_be", m_be, e_be);
            check("busy_m_wdata", m_wdata, e_wdata);
            check("busy_ready", {i_ready, d_ready}, 0);
            if (k == lat) begin
                m_ack   = 1'b1;
                m_rdata = rd;
            end else begin
                m_ack   = 1'b0;
                m_rdata = $urandom;
            end
            @(negedge clk);
        end
        got_d = d_ready;
        if (own_d) exp_d_rd = e_rd;
        else       exp_i_rd = e_rd;
        last_d = own_d;
        check("done_m_req", m_req, 0);
        check("done_i_ready", i_ready, !own_d);
        check("done_d_ready", d_ready, own_d);
        check("done_err", err, e_err);
        check("done_i_rdata", i_rdata, exp_i_rd);
        check("done_d_rdata", d_rdata, exp_d_rd);
        // stray acks outside busy must be ignored
        m_ack   = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
        if (!keep) begin
            if (own_d) d_req = 1'b0;
            else       i_req = 1'b0;
        end
        @(negedge clk);
        check_idle("post");
        m_ack   = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
    endtask

    initial begin
        bit got_d;
        rst      = 1'b1;
        i_req    = 1'b0;
        i_addr   = 32'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = 4'h0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        m_ack    = 1'b0;
        m_rdata  = 32'h0;
        last_d   = 1'b0;
        exp_i_rd = 32'h0;
        exp_d_rd = 32'h0;

        @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_ready", {i_ready, d_ready}, 0);
        check("rst_err", err, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_be", m_be, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        rst = 1'b0;

        // idle with no requests; acks ignored
        m_ack   = 1'b1;
        m_rdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("idle_ack");
        end
        m_ack = 1'b0;

        // single fetch
        i_req  = 1'b1;
        i_addr = 32'h3000;
        serve(1, 32'h8C080004, 1'b0, got_d);
        check("fetch_owner", got_d, 0);
        check("fetch_rdata", i_rdata, 32'h8C080004);

        // simultaneous, held continuously: D, I, D, I
        i_req   = 1'b1;
        i_addr  = 32'h4000;
        d_req   = 1'b1;
        d_addr  = 32'h10;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_wdata = 32'h55;
        for (int k = 0; k < 4; k++) begin
            serve(1 + k, $urandom, 1'b1, got_d);
            check("alt_seq", got_d, (k % 2) == 0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check_idle("alt_end");

        // variable latency of 5
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'h3;
        d_addr  = 32'h2000_0040;
        d_wdata = 32'h0;
        serve(5, 32'hCAFE0001, 1'b0, got_d);
        check("lat5_owner", got_d, 1);

        // reset during DBUSY
        m_ack   = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'h1;
        d_addr  = 32'h80;
        d_wdata = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_m_req", m_req, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_m_req", m_req, 0);
        check("rst_mid_d_ready", d_ready, 0);
        check("rst_mid_m_addr", m_addr, 0);
        check("rst_mid_rdata", d_rdata | i_rdata, 0);
        d_req    = 1'b0;
        exp_i_rd = 32'h0;
        exp_d_rd = 32'h0;
        last_d   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("after_rst");
        end
        i_req  = 1'b1;
        i_addr = 32'h3004;
        serve(2, 32'h00000013, 1'b0, got_d);
        check("rst_i_grant", got_d, 0);
        // last grant reset to instruction: data wins a tie
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 32'h3008;
        d_req  = 1'b1;
        serve(1, $urandom, 1'b0, got_d);
        check("tie_after_rst", got_d, 1);
        serve(1, $urandom, 1'b0, got_d);
        check("tie_second", got_d, 0);

`ifdef MEM_ARBITER_TIMEOUT_EN
        d_req = 1'b1;
        serve(100, 32'h11112222, 1'b0, got_d);
        check("to_err_rdata", d_rdata, 32'hDEADBEEF);
        i_req = 1'b1;
        serve(TB_TO, 32'h33334444, 1'b0, got_d);
        check("to_ack_wins", i_rdata, 32'h33334444);
`else
        d_req = 1'b1;
        serve(12, 32'h11112222, 1'b0, got_d);
        check("long_wait_rdata", d_rdata, 32'h11112222);
`endif

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req   = 1'b1;
                d_addr  = $urandom;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom);
                d_wdata = $urandom;
            end
            if (!i_req && !d_req) begin
                i_req  = 1'b1;
                i_addr = $urandom;
            end
            serve(int'($urandom_range(1, 7)), $urandom, $urandom_range(0, 3) == 0, got_d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of busy cycles to wait for m_ack (8-bit).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request, held until i_ready.
- i_addr  in  32  fetch address (pc).
- i_ready  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetched instruction, valid with i_ready.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load data, valid with d_ready.
- m_req  out  1  memory request, held until m_ack.
- m_we  out  1  memory write.
- m_be  out  4  memory byte enables.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_ack  in  1  memory completion; m_rdata valid this cycle.
- m_rdata  in  32  memory read data.
- err  out  1  timeout flag, valid with a ready pulse.

Function
REQ-003 The block SHALL share one unified memory port between the fetch stage and the MEM stage.
REQ-004 The FSM SHALL have four states: IDLE, IBUSY, DBUSY and DONE.
REQ-005 In IDLE with both requests low, the FSM SHALL remain in IDLE and m_req SHALL be 0.
REQ-006 In IDLE with only d_req high, the FSM SHALL go to DBUSY; with only i_req high, it SHALL go to IBUSY.
REQ-007 In IDLE with both requests high, data SHALL win, except when the previous grant was data; then instruction SHALL win.
REQ-008 At grant, the block SHALL register the winner's addr, we, be and wdata onto the m_* outputs. For an instruction grant, m_we SHALL be 0, m_be SHALL be 4'hF and m_wdata SHALL be 0.
REQ-009 m_req SHALL be 1 throughout IBUSY and DBUSY, and 0 in every other state.
REQ-010 The m_* address and data outputs SHALL stay stable while m_req is 1.
REQ-011 In a BUSY state, on m_ack the block SHALL capture m_rdata and go to DONE.
REQ-012 The ack may arrive in the first BUSY cycle, giving a 1-cycle memory latency.
REQ-013 In DONE, the block SHALL pulse the owner's ready for exactly one cycle with its rdata, then return to IDLE.
REQ-014 The non-owner's ready SHALL be 0 in DONE.
REQ-015 Latency SHALL be as follows: request sampled in IDLE at cycle t; m_req high from t+1; ack at cycle a >= t+1; ready at a+1; IDLE at a+2.
REQ-016 A requester's req still high in IDLE at a+2 SHALL be treated as a new request.
REQ-017 i_rdata and d_rdata SHALL hold their last captured value between transactions.
REQ-018 m_ack while not in a BUSY state SHALL be ignored.
REQ-019 The arbiter SHALL NOT sample requests or change the owner while in IBUSY, DBUSY or DONE.
REQ-020 Under continuous requests from both sides, neither requester SHALL wait for more than one foreign transaction.

Reset
REQ-021 While rst is high, state SHALL be IDLE and last-grant SHALL be instruction, immediately and independent of clk.
REQ-022 While rst is high, all outputs SHALL be 0.
REQ-023 Reset during BUSY SHALL drop m_req immediately, abandon the transaction and generate no ready pulse.

Configuration
REQ-024 With macro MEM_ARBITER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without m_ack.
REQ-025 With MEM_ARBITER_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL leave BUSY for DONE. It SHALL then pulse the owner's ready with rdata = 32'hDEADBEEF and err = 1.
REQ-026 With MEM_ARBITER_TIMEOUT_EN defined, m_ack in the same cycle as the counter reaching TIMEOUT SHALL win, giving a normal completion with err = 0.
REQ-027 Without MEM_ARBITER_TIMEOUT_EN, err SHALL be constant 0, no counter logic SHALL exist, and BUSY SHALL wait indefinitely for m_ack.

Verification
REQ-028 Single fetch: i_req = 1, i_addr = 0x3000, memory acks 1 cycle after m_req with 0x8C080004 -> m_addr = 0x3000, m_we = 0, i_ready one cycle later with i_rdata = 0x8C080004, d_ready = 0.
REQ-029 Simultaneous requests: i_req and d_req rise together, d_addr = 0x10, d_we = 1, d_be = 4'hF, d_wdata = 0x55 -> data serviced first, then the fetch. Both requests held continuously -> grants alternate D, I, D, I.
REQ-030 Variable latency: m_ack delayed 5 cycles -> m_req high for exactly 5 cycles, m_addr stable throughout, ready at ack + 1.
REQ-031 Reset mid-transaction: rst asserted during DBUSY -> m_req = 0 in the same cycle, no d_ready pulse. After release with only i_req high -> instruction granted.
REQ-032 Timeout (macro on, TIMEOUT = 4): no m_ack -> ready pulse on the 5th cycle after grant with err = 1 and rdata = 0xDEADBEEF. Repeat with the ack arriving in the 4th BUSY cycle -> err = 0.
